// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops a word, sends start/data(LSB first)/[parity]/stop; parity via FIFO_UART_TX_PARITY_EN.
// Latency: rd_en_o one cycle after en_i & !empty_i in IDLE; start bit two cycles after the rd_en_o cycle.
// Backpressure: pops only from IDLE when non-empty; en_i and empty_i are ignored for the rest of the frame.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 10,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  empty_i,
    output logic                  rd_en_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic [CW-1:0]         bit_cnt;
    logic [BW-1:0]         baud_cnt;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity;
`endif

    assign shift_nxt = shift_reg >> 1;
    assign busy_o    = (state != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            baud_cnt     <= '0;
            tx_o         <= 1'b1;
            rd_en_o      <= 1'b0;
            frame_done_o <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity       <= 1'b0;
`endif
        end else begin
            rd_en_o      <= 1'b0;
            frame_done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en_i && !empty_i) begin
                        rd_en_o <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    shift_reg <= rdata_i;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity    <= ^rdata_i;
`endif
                    tx_o      <= 1'b0;
                    baud_cnt  <= '0;
                    bit_cnt   <= '0;
                    state     <= S_START;
                end
                S_START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        tx_o     <= shift_reg[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_nxt;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                            tx_o    <= parity;
                            state   <= S_PARITY;
`else
                            tx_o    <= 1'b1;
                            state   <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_o    <= shift_nxt[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        tx_o     <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // bit_cnt counts stop bits here; pulse is set one cycle early so it lands on the last stop cycle
                    if (bit_cnt == STOP_LAST && baud_cnt == BAUD_PRE)
                        frame_done_o <= 1'b1;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one STOP_BITS=1 instance fed by a FIFO model, one STOP_BITS=2 instance.
module tb_fifo_uart_tx;
    localparam int DW  = 10;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, en, empty, rd_en, tx, busy, fd;
    logic [DW-1:0] rdata;
    logic          en2, empty2, rd_en2, tx2, busy2, fd2;
    logic [DW-1:0] rdata2;

    logic [DW-1:0] mem [0:31];
    int wp = 0;
    int rp = 0;
    int underflow = 0;
    int consec = 0;
    logic prev_rd = 1'b0, prev_rd2 = 1'b0;
    int checks = 0;
    int failures = 0;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .empty_i(empty), .rd_en_o(rd_en),
        .rdata_i(rdata), .tx_o(tx), .busy_o(busy), .frame_done_o(fd));

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en2), .empty_i(empty2), .rd_en_o(rd_en2),
        .rdata_i(rdata2), .tx_o(tx2), .busy_o(busy2), .frame_done_o(fd2));

    assign empty = (wp == rp);

    // FIFO model: the popped word appears on rdata the cycle after rd_en
    always @(posedge clk) begin
        if (rd_en) begin
            if (wp == rp) begin
                underflow <= underflow + 1;
            end else begin
                rdata <= mem[rp];
                rp    <= rp + 1;
            end
        end
    end

    always @(negedge clk) begin
        if ((rd_en && prev_rd) || (rd_en2 && prev_rd2)) consec <= consec + 1;
        prev_rd  <= rd_en;
        prev_rd2 <= rd_en2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wp] = w;
        wp = wp + 1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rd(output logic found);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (rd_en) found = 1'b1;
        end
    endtask

    task automatic count_pulses(input int n, output int nrd, output int nfd);
        nrd = 0;
        nfd = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rd_en) nrd++;
            if (fd) nfd++;
        end
    endtask

    task automatic capture(output logic [127:0] tv, output logic [127:0] fv, output logic [127:0] bv,
                           output logic [127:0] tv2, output logic [127:0] fv2, output logic [127:0] bv2,
                           output int rdc);
        rdc = 0;
        for (int i = 0; i < 128; i++) begin
            tv[i] = tx;   fv[i] = fd;   bv[i] = busy;
            tv2[i] = tx2; fv2[i] = fd2; bv2[i] = busy2;
            if (rd_en) rdc++;
            @(negedge clk);
        end
    endtask

    // Expected line/frame_done/busy waveform for one frame starting at cycle pos
    task automatic put_frame(inout logic [127:0] t, inout logic [127:0] f, inout logic [127:0] b,
                             inout int pos, input logic [DW-1:0] d, input int sb);
        int seq[$];
        seq.push_back(0);
        for (int k = 0; k < DW; k++) seq.push_back(int'(d[k]));
        if (PAR != 0) seq.push_back(int'(^d));
        for (int k = 0; k < sb; k++) seq.push_back(1);
        foreach (seq[j]) begin
            for (int c = 0; c < CPB; c++) begin
                t[pos] = (seq[j] != 0);
                b[pos] = 1'b1;
                pos++;
            end
        end
        f[pos-1] = 1'b1;
    endtask

    logic [127:0] tv, fv, bv, tv2, fv2, bv2;
    logic [127:0] et, ef, eb, et2, ef2, eb2;
    int   rdc, pos, pos2, nrd, nfd;
    logic found;

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        en2    = 1'b1;
        empty2 = 1'b0;
        rdata2 = 10'h2A5;
        push(10'h2A5);

        // Reset held with work pending: line idle, no pops
        repeat (5) begin
            @(negedge clk);
            chk("reset_outs", {tx, rd_en, busy, fd}, 4'b1000);
            chk("reset_outs2", {tx2, rd_en2, busy2, fd2}, 4'b1000);
        end
        rst_n = 1'b1;
        step(1);
        chk("first_pop", rd_en, 1'b1);
        chk("first_pop2", rd_en2, 1'b1);
        empty2 = 1'b1;
        step(1);
        chk("wait_tx_high", {tx, busy}, 2'b11);
        step(1);
        chk("start_low", tx, 1'b0);

        // Single word 2A5 on both instances
        capture(tv, fv, bv, tv2, fv2, bv2, rdc);
        et = '1; ef = '0; eb = '0; pos = 0;
        put_frame(et, ef, eb, pos, 10'h2A5, 1);
        et2 = '1; ef2 = '0; eb2 = '0; pos2 = 0;
        put_frame(et2, ef2, eb2, pos2, 10'h2A5, 2);
        chk("single_tx", tv, et);
        chk("single_done", fv, ef);
        chk("single_busy", bv, eb);
        chk("single_no_extra_pop", rdc, 0);
        chk("stop2_tx", tv2, et2);
        chk("stop2_done", fv2, ef2);
        chk("stop2_busy", bv2, eb2);

        // Back-to-back 000 then 3FF
        push(10'h000);
        push(10'h3FF);
        wait_rd(found);
        chk("b2b_pop_seen", found, 1'b1);
        step(2);
        capture(tv, fv, bv, tv2, fv2, bv2, rdc);
        et = '1; ef = '0; eb = '0; pos = 0;
        put_frame(et, ef, eb, pos, 10'h000, 1);
        eb[pos+1] = 1'b1;
        eb[pos+2] = 1'b1;
        pos = pos + 3;
        put_frame(et, ef, eb, pos, 10'h3FF, 1);
        chk("b2b_tx", tv, et);
        chk("b2b_done", fv, ef);
        chk("b2b_busy", bv, eb);
        chk("b2b_second_pop", rdc, 1);

        // Enable gating
        en = 1'b0;
        push(10'h155);
        count_pulses(100, nrd, nfd);
        chk("en_low_no_pop", nrd, 0);
        en = 1'b1;
        wait_rd(found);
        chk("en_high_pop_seen", found, 1'b1);
        step(10);
        chk("mid_data_busy", busy, 1'b1);
        en = 1'b0;
        push(10'h0AA);
        count_pulses(100, nrd, nfd);
        chk("en_drop_frame_done", nfd, 1);
        chk("en_drop_no_pop", nrd, 0);
        chk("en_drop_idle", {tx, busy}, 2'b10);

        // Reset mid-DATA while sending 0AA (bit0 = 0 on the line at cycle 6)
        en = 1'b1;
        wait_rd(found);
        chk("rst_test_pop_seen", found, 1'b1);
        step(8);
        chk("pre_reset_line", {tx, busy}, 2'b01);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {tx, busy, rd_en, fd}, 4'b1000);
        step(3);
        rst_n = 1'b1;
        count_pulses(20, nrd, nfd);
        chk("post_reset_empty_no_pop", nrd, 0);
        en = 1'b0;
        push(10'h0F0);
        count_pulses(20, nrd, nfd);
        chk("post_reset_en_low_no_pop", nrd, 0);
        en = 1'b1;
        wait_rd(found);
        chk("post_reset_pop_seen", found, 1'b1);
        step(2);
        capture(tv, fv, bv, tv2, fv2, bv2, rdc);
        et = '1; ef = '0; eb = '0; pos = 0;
        put_frame(et, ef, eb, pos, 10'h0F0, 1);
        chk("post_reset_tx", tv, et);
        chk("post_reset_done", fv, ef);

        chk("no_underflow", underflow, 0);
        chk("no_consecutive_rd_en", consec, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
